// File: rtl/countdown_ctrl.sv
// Countdown timer sequencer: owns the user preset, drives load/enable of the external
// seconds counter, detects expiry and generates the alarm and display blink enable.
module countdown_ctrl #(
  parameter int BITS_NUM       = 14,
  parameter int MAX_VALUE      = 9999,
  parameter int DEFAULT_PRESET = 60,
  parameter int STEP           = 1,
  parameter int BLINK_TICKS    = 5,
  parameter int ALARM_TICKS    = 50
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                CE,
  input  logic                TICK,
  input  logic                KEY_START,
  input  logic                KEY_RESET,
  input  logic                KEY_INC,
  input  logic                KEY_DEC,
  input  logic                CNT_ZERO,
  output logic [BITS_NUM-1:0] PRESET,
  output logic                CNT_LOAD,
  output logic                CNT_CE,
  output logic                ALARM,
  output logic                DISP_ON,
  output logic [2:0]          STATE
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3
  } state_t;

  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int ALARM_W = $clog2(ALARM_TICKS + 1);
  localparam logic [BITS_NUM-1:0] MAX_P  = BITS_NUM'(MAX_VALUE);
  localparam logic [BITS_NUM-1:0] STEP_P = BITS_NUM'(STEP);
  localparam logic [BITS_NUM-1:0] DEF_P  = BITS_NUM'(DEFAULT_PRESET);

  state_t               state;
  state_t               next_state;
  logic [BLINK_W-1:0]   blink_cnt;
  logic [ALARM_W-1:0]   alarm_cnt;
  logic                 start_ok;
  logic                 alarm_expire;
  logic                 blink_wrap;
  logic                 entering;
  logic                 blinking;

  assign start_ok     = KEY_START && (PRESET != '0);
  assign alarm_expire = TICK && (alarm_cnt == ALARM_W'(ALARM_TICKS - 1));
  assign blink_wrap   = blink_cnt == BLINK_W'(BLINK_TICKS - 1);
  assign entering     = next_state != state;
  assign blinking     = (state == PAUSE) || (state == DONE);
  assign STATE        = state;

  always_ff @(posedge CLK) begin
    if (CLR)
      state <= IDLE;
    else if (CE)
      state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = start_ok ? RUN : IDLE;
      RUN: begin
        if (CNT_ZERO)       next_state = DONE;
        else if (KEY_RESET) next_state = IDLE;
        else if (KEY_START) next_state = PAUSE;
        else                next_state = RUN;
      end
      PAUSE: begin
        if (KEY_RESET)      next_state = IDLE;
        else if (KEY_START) next_state = RUN;
        else                next_state = PAUSE;
      end
      DONE:    next_state = (KEY_START || KEY_RESET || alarm_expire) ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end

  // While idle the counter continuously mirrors PRESET so a start always counts from it
  always_comb begin
    CNT_LOAD = 1'b0;
    CNT_CE   = 1'b0;
    if (CE) begin
      case (state)
        IDLE:    CNT_LOAD = 1'b1;
        RUN:     CNT_CE   = TICK && !CNT_ZERO;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR)
      PRESET <= DEF_P;
    else if (CE && (state == IDLE) && !start_ok && (KEY_INC ^ KEY_DEC)) begin
      if (KEY_INC)
        PRESET <= (PRESET > MAX_P - STEP_P) ? MAX_P : PRESET + STEP_P;
      else
        PRESET <= (PRESET < STEP_P) ? '0 : PRESET - STEP_P;
    end
  end

  // Any state entry restarts the blink phase with the display lit
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ALARM     <= 1'b0;
      DISP_ON   <= 1'b1;
      blink_cnt <= '0;
      alarm_cnt <= '0;
    end else if (CE) begin
      ALARM <= next_state == DONE;
      if (entering || !blinking) begin
        DISP_ON   <= 1'b1;
        blink_cnt <= '0;
      end else if (TICK) begin
        if (blink_wrap) begin
          blink_cnt <= '0;
          DISP_ON   <= !DISP_ON;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
      if (entering)
        alarm_cnt <= '0;
      else if ((state == DONE) && TICK)
        alarm_cnt <= alarm_cnt + ALARM_W'(1);
    end
  end

endmodule
